sopc_test_ctrl: RTL and testbench
=================================

// Module: sopc_test_ctrl
// PURPOSE
//   Parametrised run controller for min-SOPC simulation and FPGA bring-up. Sequences core reset
//   release, counts run cycles, and snoops NUM_CH register-writeback ports for a done signature.
//   Signals pass/fail/timeout and halts the core. Instantiated beside openmips_min_sopc, driven by
//   the board/bench clock. Replaces fixed #delay reset and $stop timing.
// PARAMETERS
//   RST_CYCLES  10            clk cycles core_rst_o is held after rst release / restart (>=1)
//   MAX_CYCLES  50            run-cycle budget before TIMEOUT; 0 = timeout disabled
//   NUM_CH      1             number of writeback channels snooped
//   AW          5             writeback register-address width
//   DW          32            writeback data width
//   CNT_W       32            cycle counter width
//   DONE_REG    5'd31         register address whose write ends the test
//   PASS_CODE   32'h0000_0001 data value on DONE_REG meaning pass; any other value = fail
// PORTS
//   clk            in   1         system clock
//   rst            in   1         async reset, active-low
//   restart_i      in   1         sync pulse: restart sequence from HOLD
//   wb_we_i        in   NUM_CH    per-channel writeback enable
//   wb_waddr_i     in   NUM_CH*AW per-channel address, ch k at [k*AW +: AW]
//   wb_wdata_i     in   NUM_CH*DW per-channel data, ch k at [k*DW +: DW]
//   core_rst_o     out  1         active-high reset to SOPC core
//   halt_o         out  1         1 in any terminal state
//   done_o         out  1         1 in PASS or FAIL
//   pass_o         out  1         1 in PASS
//   fail_o         out  1         1 in FAIL
//   timeout_o      out  1         1 in TIMEOUT
//   cycle_cnt_o    out  CNT_W     run cycles elapsed
//   result_o       out  DW        data of the terminating DONE_REG write
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-low (clk, rst).
//   - rst low: state=HOLD, hold counter=0, core_rst_o=1, cycle_cnt_o=0, result_o=0, all flags 0.
//   - States: HOLD -> RUN -> {PASS, FAIL, TIMEOUT}. All outputs registered, decoded from state.
//   - HOLD: hold counter increments each clk; on the cycle it equals RST_CYCLES-1 go to RUN, so
//     core_rst_o is 1 for exactly RST_CYCLES clk edges after rst rises. Writebacks ignored.
//   - RUN: core_rst_o=0. cycle_cnt_o =0 in first RUN cycle, +1 per clk, saturates at all-ones.
//   - Match: channel k hits when wb_we_i[k]=1 and its addr==DONE_REG. Several hits same cycle:
//     lowest k wins. Hit data==PASS_CODE -> PASS, else -> FAIL; result_o <= hit data. Flags
//     visible the clk after the hit (1-cycle latency).
//   - Timeout: in RUN with MAX_CYCLES!=0 and cycle_cnt_o==MAX_CYCLES-1 and no hit -> TIMEOUT.
//     Hit on that same cycle wins over timeout.
//   - Terminal states: sticky, halt_o=1, core_rst_o=1 (core frozen), cycle_cnt_o and result_o
//     frozen. Further writebacks ignored.
//   - restart_i=1 in any state: next state HOLD, hold counter=0, cycle_cnt_o=0, result_o=0,
//     flags cleared, core_rst_o=1. restart_i has priority over hit and timeout. Asserting it
//     during HOLD restarts the hold count.
//   - rst low mid-run: immediate async return to reset values, no clock needed.
//   - Exactly one of pass_o/fail_o/timeout_o may be 1; done_o = pass_o|fail_o.
// TESTING
//   1 Defaults, rst low 3 clk then high -> core_rst_o=1 for 10 edges, falls; cycle_cnt_o 0,1,2..
//   2 RUN cycle 7: ch0 we=1 addr=31 data=1 -> next clk pass_o=done_o=halt_o=core_rst_o=1,
//     result_o=1, cycle_cnt_o=7 frozen.
//   3 NUM_CH=2, same cycle ch0 addr=31 data=5, ch1 addr=31 data=1 -> fail_o=1, result_o=5.
//   4 No hit -> timeout_o=1 after cycle_cnt_o=49; hit on cycle 49 instead -> pass, no timeout.
//   5 In PASS pulse restart_i 1 clk -> flags clear, core_rst_o=1 for 10 edges, RUN resumes at 0.
//   6 rst low during RUN cycle 20 -> outputs at reset values before next clk edge; addr=30
//     writes and writes during HOLD never end the test; MAX_CYCLES=0 runs 1000 cycles, no timeout.

Source files
------------

// File: rtl/sopc_test_ctrl_if.sv
// Writeback snoop bundle: NUM_CH register-file write ports observed by the run controller.
// Channel k occupies bits [k*AW +: AW] of the address and [k*DW +: DW] of the data.
interface sopc_test_ctrl_if #(
   parameter int NUM_CH = 1,
   parameter int AW     = 5,
   parameter int DW     = 32
);
   logic [NUM_CH-1:0]    wb_we;
   logic [NUM_CH*AW-1:0] wb_waddr;
   logic [NUM_CH*DW-1:0] wb_wdata;

   modport master (output wb_we, output wb_waddr, output wb_wdata);
   modport slave  (input  wb_we, input  wb_waddr, input  wb_wdata);
endinterface

// File: rtl/sopc_test_ctrl.sv
// Run controller for min-SOPC bring-up: holds the core in reset, counts run cycles and ends the
// test on a write to DONE_REG (pass/fail by data) or on cycle-budget exhaustion (timeout).
//
// state     | meaning
// S_HOLD    | core held in reset for RST_CYCLES edges, writebacks ignored
// S_RUN     | core running, cycle counter advancing, snooping writebacks
// S_PASS    | DONE_REG written with PASS_CODE, core frozen
// S_FAIL    | DONE_REG written with any other value, core frozen
// S_TIMEOUT | run budget spent without a DONE_REG write, core frozen
module sopc_test_ctrl #(
   parameter int              RST_CYCLES = 10,
   parameter int              MAX_CYCLES = 50,
   parameter int              NUM_CH     = 1,
   parameter int              AW         = 5,
   parameter int              DW         = 32,
   parameter int              CNT_W      = 32,
   parameter logic [AW-1:0]   DONE_REG   = 5'd31,
   parameter logic [DW-1:0]   PASS_CODE  = 32'h0000_0001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart_i,
   sopc_test_ctrl_if.slave  wb,
   output logic             core_rst_o,
   output logic             halt_o,
   output logic             done_o,
   output logic             pass_o,
   output logic             fail_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [DW-1:0]    result_o
);

   localparam int             HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [HW-1:0]  HOLD_LAST = HW'(RST_CYCLES - 1);
   localparam bit             TO_EN     = (MAX_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_CNT  = TO_EN ? CNT_W'(MAX_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      S_HOLD    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    result_q, result_d;

   logic             hit;
   logic [DW-1:0]    hit_data;

   // Scan from the top channel down so the lowest matching channel is the one left standing.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (wb.wb_we[k] && (wb.wb_waddr[k*AW +: AW] == DONE_REG)) begin
            hit      = 1'b1;
            hit_data = wb.wb_wdata[k*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_HOLD;
         hold_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (restart_i) begin
         state_d  = S_HOLD;
         hold_d   = '0;
         cnt_d    = '0;
         result_d = '0;
      end else begin
         case (state_q)
            S_HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  state_d = S_RUN;
                  hold_d  = '0;
                  cnt_d   = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            S_RUN: begin
               // The counter stops on the terminating cycle so it reports the cycle of the event.
               if (hit) begin
                  state_d  = (hit_data == PASS_CODE) ? S_PASS : S_FAIL;
                  result_d = hit_data;
               end else if (TO_EN && (cnt_q == TO_CNT)) begin
                  state_d = S_TIMEOUT;
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      core_rst_o  = (state_q != S_RUN);
      halt_o      = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);
      pass_o      = (state_q == S_PASS);
      fail_o      = (state_q == S_FAIL);
      timeout_o   = (state_q == S_TIMEOUT);
      done_o      = (state_q == S_PASS) || (state_q == S_FAIL);
      cycle_cnt_o = cnt_q;
      result_o    = result_q;
   end

endmodule

// File: tb/tb_sopc_test_ctrl.sv
// Bench for sopc_test_ctrl: two instances (2 channels / 50-cycle budget, 1 channel / no budget)
// compared every cycle against a behavioural model, plus directed literal checkpoints.
module tb_sopc_test_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        restart = 1'b0;
   logic [1:0]  we = '0;
   logic [9:0]  addr = '0;
   logic [63:0] data = '0;

   logic [1:0]  core_rst_w, halt_w, done_w, pass_w, fail_w, timeout_w;
   logic [31:0] cnt_w [2];
   logic [31:0] res_w [2];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   sopc_test_ctrl_if #(.NUM_CH(2), .AW(5), .DW(32)) if_a ();
   sopc_test_ctrl_if #(.NUM_CH(1), .AW(5), .DW(32)) if_b ();

   assign if_a.wb_we    = we;
   assign if_a.wb_waddr = addr;
   assign if_a.wb_wdata = data;
   assign if_b.wb_we    = we[0];
   assign if_b.wb_waddr = addr[4:0];
   assign if_b.wb_wdata = data[31:0];

   sopc_test_ctrl #(.RST_CYCLES(10), .MAX_CYCLES(50), .NUM_CH(2)) dut_a (
      .clk(clk), .rst(rst), .restart_i(restart), .wb(if_a),
      .core_rst_o(core_rst_w[0]), .halt_o(halt_w[0]), .done_o(done_w[0]), .pass_o(pass_w[0]),
      .fail_o(fail_w[0]), .timeout_o(timeout_w[0]), .cycle_cnt_o(cnt_w[0]), .result_o(res_w[0]));

   sopc_test_ctrl #(.RST_CYCLES(10), .MAX_CYCLES(0), .NUM_CH(1)) dut_b (
      .clk(clk), .rst(rst), .restart_i(restart), .wb(if_b),
      .core_rst_o(core_rst_w[1]), .halt_o(halt_w[1]), .done_o(done_w[1]), .pass_o(pass_w[1]),
      .fail_o(fail_w[1]), .timeout_o(timeout_w[1]), .cycle_cnt_o(cnt_w[1]), .result_o(res_w[1]));

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
   endtask

   // Model: phase 0=hold 1=run 2=pass 3=fail 4=timeout; hold tracked as edges still to wait.
   int          m_st   [2] = '{0, 0};
   int          m_left [2] = '{10, 10};
   longint      m_cnt  [2] = '{0, 0};
   logic [31:0] m_res  [2] = '{32'd0, 32'd0};

   function automatic int nch(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic longint budget(input int i);
      return (i == 0) ? 50 : 0;
   endfunction

   task automatic model_clear(input int i);
      m_st[i] = 0; m_left[i] = 10; m_cnt[i] = 0; m_res[i] = 32'd0;
   endtask

   task automatic model_step(input int i);
      int found;
      if (!rst || restart) begin
         model_clear(i);
      end else if (m_st[i] == 0) begin
         m_left[i]--;
         if (m_left[i] == 0) begin m_st[i] = 1; m_cnt[i] = 0; end
      end else if (m_st[i] == 1) begin
         found = -1;
         for (int k = 0; k < nch(i); k++)
            if (found < 0 && we[k] && addr[k*5 +: 5] == 5'd31) found = k;
         if (found >= 0) begin
            m_res[i] = data[found*32 +: 32];
            m_st[i]  = (m_res[i] == 32'd1) ? 2 : 3;
         end else if (budget(i) != 0 && m_cnt[i] == budget(i) - 1) begin
            m_st[i] = 4;
         end else if (m_cnt[i] < 64'hFFFF_FFFF) begin
            m_cnt[i]++;
         end
      end
   endtask

   always @(negedge rst) begin
      model_clear(0);
      model_clear(1);
   end

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("core_rst_%0d", i), core_rst_w[i], m_st[i] != 1);
         check($sformatf("halt_%0d", i), halt_w[i], m_st[i] >= 2);
         check($sformatf("done_%0d", i), done_w[i], m_st[i] == 2 || m_st[i] == 3);
         check($sformatf("pass_%0d", i), pass_w[i], m_st[i] == 2);
         check($sformatf("fail_%0d", i), fail_w[i], m_st[i] == 3);
         check($sformatf("timeout_%0d", i), timeout_w[i], m_st[i] == 4);
         check($sformatf("cycle_cnt_%0d", i), cnt_w[i], m_cnt[i]);
         check($sformatf("result_%0d", i), res_w[i], m_res[i]);
      end
   end

   task automatic wait_cnt(input int i, input longint target);
      bit ok = 0;
      for (int n = 0; n < 2000 && !ok; n++) begin
         @(negedge clk);
         if (m_st[i] == 1 && m_cnt[i] == target) ok = 1;
      end
      check($sformatf("wait_cnt_%0d_reached", target), ok, 1);
   endtask

   task automatic do_restart();
      @(negedge clk) restart = 1'b1;
      @(negedge clk) restart = 1'b0;
   endtask

   task automatic count_hold_edges(input string name);
      int edges = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #2;
         edges++;
         if (!core_rst_w[0]) break;
      end
      check(name, edges, 10);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got time %0t expected under 400000", $time);
      $fatal(1);
   end

   initial begin
      // 1: reset and release, exact hold length, counter start
      repeat (3) @(posedge clk);
      #1;
      check("rst_core_rst", core_rst_w[0], 1);
      check("rst_cnt", cnt_w[0], 0);
      @(negedge clk) rst = 1'b1;
      count_hold_edges("hold_edges_after_rst");
      check("run_cnt0", cnt_w[0], 0);
      @(posedge clk); #2 check("run_cnt1", cnt_w[0], 1);
      @(posedge clk); #2 check("run_cnt2", cnt_w[0], 2);

      // 2: pass on run cycle 7
      wait_cnt(0, 7);
      we = 2'b01; addr = {5'd0, 5'd31}; data = {32'd0, 32'd1};
      @(negedge clk) we = '0;
      check("p2_pass", pass_w[0], 1);
      check("p2_done", done_w[0], 1);
      check("p2_halt", halt_w[0], 1);
      check("p2_core_rst", core_rst_w[0], 1);
      check("p2_result", res_w[0], 1);
      check("p2_cnt", cnt_w[0], 7);
      repeat (3) @(negedge clk);
      check("p2_cnt_frozen", cnt_w[0], 7);

      // 5: restart out of PASS
      @(negedge clk) restart = 1'b1;
      @(posedge clk); #2;
      check("rs_pass_clr", pass_w[0], 0);
      check("rs_core_rst", core_rst_w[0], 1);
      check("rs_result_clr", res_w[0], 0);
      @(negedge clk) restart = 1'b0;
      count_hold_edges("hold_edges_after_restart");
      check("rs_run_cnt0", cnt_w[0], 0);

      // 3: simultaneous hits, lowest channel wins
      wait_cnt(0, 3);
      we = 2'b11; addr = {5'd31, 5'd31}; data = {32'd1, 32'd5};
      @(negedge clk) we = '0;
      check("p3_fail", fail_w[0], 1);
      check("p3_pass", pass_w[0], 0);
      check("p3_result", res_w[0], 5);

      // 4: timeout, then hit on the last budget cycle
      do_restart();
      for (int n = 0; n < 200; n++) begin
         @(posedge clk); #2;
         if (timeout_w[0]) break;
      end
      check("p4_timeout", timeout_w[0], 1);
      check("p4_cnt", cnt_w[0], 49);
      check("p4_done", done_w[0], 0);
      do_restart();
      wait_cnt(0, 49);
      we = 2'b01; addr = {5'd0, 5'd31}; data = {32'd0, 32'd1};
      @(negedge clk) we = '0;
      check("p4_hit49_pass", pass_w[0], 1);
      check("p4_hit49_no_to", timeout_w[0], 0);
      check("p4_hit49_cnt", cnt_w[0], 49);

      // 6: writes during HOLD and to address 30 never end the test; async reset mid-run
      do_restart();
      for (int n = 0; n < 8; n++) begin
         we = 2'b11; addr = {5'd31, 5'd31}; data = {$urandom, $urandom};
         @(negedge clk);
      end
      we = '0;
      wait_cnt(0, 0);
      while (m_cnt[0] < 20 && m_st[0] == 1) begin
         we = 2'(($urandom_range(3))); addr = {5'd30, 5'd30}; data = {$urandom, $urandom};
         @(negedge clk);
      end
      we = '0;
      check("p6_no_end", halt_w[0], 0);
      check("p6_cnt20", cnt_w[0], 20);
      @(posedge clk); #3 rst = 1'b0;
      #1;
      check("p6_async_core_rst", core_rst_w[0], 1);
      check("p6_async_cnt", cnt_w[0], 0);
      check("p6_async_halt", halt_w[0], 0);
      @(negedge clk) rst = 1'b1;

      // MAX_CYCLES=0 instance must keep running
      for (int n = 0; n < 1100; n++) begin
         @(negedge clk);
         if (m_cnt[1] >= 1000) break;
      end
      check("b_long_no_timeout", timeout_w[1], 0);
      check("b_long_cnt_ge_1000", cnt_w[1] >= 1000, 1);

      // randomized traffic with occasional restarts
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         restart = ($urandom_range(99) == 0);
         we      = 2'($urandom_range(3));
         for (int k = 0; k < 2; k++) begin
            addr[k*5 +: 5]  = ($urandom_range(39) == 0) ? 5'd31 : 5'($urandom_range(30));
            data[k*32 +: 32] = ($urandom_range(1) == 1) ? 32'd1 : $urandom;
         end
      end
      @(negedge clk);
      restart = 1'b0; we = '0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
